axi_tb_mst: RTL and testbench
=============================

Name: axi_tb_mst

Overview:
Testbench AXI4 initiator: the manager-side counterpart of the bench AXI subordinate memory model. It converts simple single-beat read/write commands from a bench sequencer into AXI AR/R and AW/W/B traffic (64-bit data, arlen/awlen=0). It returns one response per command and flags protocol violations and timeouts. It has one outstanding transaction at a time and sits between the directed-test sequencer and any AXI subordinate port.

Parameters:
TAGW, 1, width of arid/awid/rid/bid and of the command tag
TIMEOUT, 1024, max cycles waiting in any bus state before abort; 0 disables the timeout

Ports:
aclk  in  1  clock
rst_l  in  1  asynchronous active-low reset
cmd_valid / cmd_ready  in / out  1 / 1  command handshake
cmd_write, cmd_size, cmd_addr  in  1, 3, 32  direction, AXI size encoding, byte address
cmd_wdata, cmd_tag  in  64, TAGW  lane-aligned write data; ID driven on arid/awid
rsp_valid / rsp_ready  out / in  1 / 1  response handshake
rsp_write, rsp_resp, rsp_rdata, rsp_tag  out  1, 2, 64, TAGW  completed-command info
arvalid out 1, arready in 1, araddr out 32, arid out TAGW, arlen out 8, arburst out 2, arsize out 3
rvalid in 1, rready out 1, rdata in 64, rresp in 2, rid in TAGW, rlast in 1
awvalid out 1, awready in 1, awaddr out 32, awid out TAGW, awlen out 8, awburst out 2, awsize out 3
wvalid out 1, wready in 1, wdata out 64, wstrb out 8, wlast out 1
bvalid in 1, bready out 1, bresp in 2, bid in TAGW
busy  out  1  state != IDLE
err_proto, err_timeout  out  1  sticky error flags, cleared only by reset

Behaviour:
- States: IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, RSP.
- Reset: state IDLE. All valids, rready, bready, rsp_valid, err flags = 0. Latched fields = 0.
- cmd_ready = (state==IDLE), combinational. Fire = cmd_valid & cmd_ready. Fire latches cmd fields.
- Fixed outputs: arlen=awlen=0, arburst=awburst=2'b01 (INCR), wlast=1. All bus outputs are registered; first valid appears the cycle after fire.
- Alignment check at fire: cmd_size>3, or cmd_addr not a multiple of 2^size. Either gives state RSP with rsp_resp=2'b10, rsp_rdata=0, and no bus traffic.
- wstrb by size:
  - 0: 8'h01<<addr[2:0]
  - 1: 8'h03<<{addr[2:1],0}
  - 2: 8'h0f<<{addr[2],00}
  - 3: 8'hff
- Read path:
  - RD_ADDR: arvalid held, araddr=cmd_addr, arsize=cmd_size, until arready → RD_DATA.
  - RD_DATA: rready=1. On rvalid, capture rdata/rresp → RSP.
  - rid != tag or rlast=0 sets err_proto; the response is still returned.
- Write path (WR):
  - On entry, awvalid and wvalid are both 1.
  - Each valid drops independently on its own handshake; a simultaneous handshake of both is legal.
  - bready=1 once the W handshake is done. This covers subordinates that return B before AW completes.
  - B accepted before AW done: capture bresp and keep holding awvalid.
  - Go to RSP when AW done and B received. If AW and W are done without B → WR_RESP, bready=1, wait for bvalid.
  - bid != tag sets err_proto.
- RSP: rsp_valid=1 with rsp_tag, rsp_write, rsp_resp, rsp_rdata (0 for writes). Held stable until rsp_ready → IDLE.
- Timeout: cycle counter cleared on fire and counts in RD_ADDR, RD_DATA, WR, WR_RESP. When it reaches TIMEOUT:
  - all AXI valids and readies drop next cycle;
  - rsp_resp=2'b11;
  - err_timeout=1;
  - state → RSP.
  - Counter saturates and never wraps.
- Beats outside a wait (rvalid outside RD_DATA, bvalid outside WR/WR_RESP) are ignored (not accepted) and set err_proto.
- Reset mid-operation: everything returns to reset values immediately. The in-flight command is dropped with no response.

Decomposition:
- Package axi_tb_pkg holds:
  - state enum;
  - RESP_OKAY/SLVERR/DECERR constants;
  - BURST_INCR constant;
  - function size_to_strb(size, addr[2:0]);
  - function is_misaligned(size, addr).
- Optional sub-module axi_tb_mst_tmo (saturating timeout counter with clear/enable/expire). Everything else stays in one module.

Test Plan:
- Write 64'h1122334455667788 size 3 to 0x1000, then read 0x1000 against the bench subordinate → B OKAY; read returns 64'h1122334455667788, rsp_resp=0, tag echoed.
- Write size 0 to 0x1003 with data 64'hAB<<24 → wstrb=8'h08. A size 3 read back shows byte 3=0xAB and other bytes unchanged.
- Command size 2 to addr 0x1002 → no arvalid/awvalid ever; rsp_resp=2'b10 two cycles after fire.
- Subordinate holds awready=0 for 5 cycles while wready=1 and B returns early → wvalid drops after 1 cycle, awvalid held 6 cycles; a single response with OKAY.
- TIMEOUT=16 with arready tied 0 → arvalid drops after 16 cycles; rsp_resp=2'b11; err_timeout=1 and stays 1.
- rid mismatch (tag 0, rid 1), then rst_l pulsed mid-RD_DATA → err_proto=1 after the first read; after reset all valids and flags are 0 and cmd_ready=1.

Source files
------------

// File: rtl/axi_tb_pkg.sv
// Shared types and helpers for the bench-side AXI4 single-beat initiator.
// Holds the state encoding, response/burst constants and strobe/alignment helpers.
package axi_tb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR,
    WR_RESP,
    RSP
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  // Byte lanes touched by a naturally aligned access on a 64-bit bus.
  function automatic logic [7:0] size_to_strb(input logic [2:0] size, input logic [2:0] addr);
    case (size)
      3'd0:    return 8'h01 << addr;
      3'd1:    return 8'h03 << {addr[2:1], 1'b0};
      3'd2:    return 8'h0f << {addr[2], 2'b00};
      default: return 8'hff;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] size, input logic [2:0] addr);
    case (size)
      3'd0:    return 1'b0;
      3'd1:    return addr[0];
      3'd2:    return |addr[1:0];
      3'd3:    return |addr[2:0];
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/axi_tb_mst_tmo.sv
// Saturating wait counter: cleared on a new command, counts while enabled,
// flags expiry in the cycle the count would reach TIMEOUT (TIMEOUT=0 disables).
module axi_tb_mst_tmo #(
  parameter int TIMEOUT = 1024
) (
  input  logic i_aclk,
  input  logic i_rst_l,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expire
);

  localparam int            CW  = $clog2(TIMEOUT + 2);
  localparam bit            ENA = (TIMEOUT != 0);
  localparam logic [CW-1:0] MAX = CW'(TIMEOUT);
  localparam logic [CW-1:0] LIM = ENA ? CW'(TIMEOUT - 1) : '0;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_aclk or negedge i_rst_l) begin
    if (!i_rst_l) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != MAX)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_expire = ENA && i_en && (r_cnt == LIM);

endmodule

// File: rtl/axi_tb_mst.sv
// Bench AXI4 initiator: turns single-beat read/write commands into AR/R or AW/W/B
// traffic, one transaction in flight, with sticky protocol and timeout error flags.
module axi_tb_mst
  import axi_tb_pkg::*;
#(
  parameter int TAGW    = 1,
  parameter int TIMEOUT = 1024
) (
  input  logic            aclk,
  input  logic            rst_l,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_write,
  input  logic [2:0]      cmd_size,
  input  logic [31:0]     cmd_addr,
  input  logic [63:0]     cmd_wdata,
  input  logic [TAGW-1:0] cmd_tag,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_write,
  output logic [1:0]      rsp_resp,
  output logic [63:0]     rsp_rdata,
  output logic [TAGW-1:0] rsp_tag,
  output logic            arvalid,
  input  logic            arready,
  output logic [31:0]     araddr,
  output logic [TAGW-1:0] arid,
  output logic [7:0]      arlen,
  output logic [1:0]      arburst,
  output logic [2:0]      arsize,
  input  logic            rvalid,
  output logic            rready,
  input  logic [63:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic [TAGW-1:0] rid,
  input  logic            rlast,
  output logic            awvalid,
  input  logic            awready,
  output logic [31:0]     awaddr,
  output logic [TAGW-1:0] awid,
  output logic [7:0]      awlen,
  output logic [1:0]      awburst,
  output logic [2:0]      awsize,
  output logic            wvalid,
  input  logic            wready,
  output logic [63:0]     wdata,
  output logic [7:0]      wstrb,
  output logic            wlast,
  input  logic            bvalid,
  output logic            bready,
  input  logic [1:0]      bresp,
  input  logic [TAGW-1:0] bid,
  output logic            busy,
  output logic            err_proto,
  output logic            err_timeout
);

  state_e          r_state, w_nxt_state;
  logic            r_write;
  logic [2:0]      r_size;
  logic [31:0]     r_addr;
  logic [63:0]     r_wdata;
  logic [7:0]      r_wstrb;
  logic [TAGW-1:0] r_tag;
  logic            r_arvalid, r_rready, r_awvalid, r_wvalid, r_bready, r_bgot;
  logic            r_rsp_valid, r_err_proto, r_err_timeout;
  logic [1:0]      r_rsp_resp;
  logic [63:0]     r_rsp_rdata;

  logic            w_nxt_arvalid, w_nxt_rready, w_nxt_awvalid, w_nxt_wvalid;
  logic            w_nxt_bready, w_nxt_bgot, w_nxt_rsp_valid;
  logic            w_nxt_err_proto, w_nxt_err_timeout;
  logic [1:0]      w_nxt_rsp_resp;
  logic [63:0]     w_nxt_rsp_rdata;

  logic w_fire, w_tmo_en, w_expire, w_stray;
  logic w_aw_hs, w_w_hs, w_b_hs, w_aw_done, w_w_done;

  assign w_fire    = cmd_valid && (r_state == IDLE);
  assign w_tmo_en  = r_state inside {RD_ADDR, RD_DATA, WR, WR_RESP};
  assign w_aw_hs   = r_awvalid && awready;
  assign w_w_hs    = r_wvalid && wready;
  assign w_b_hs    = bvalid && r_bready;
  assign w_aw_done = !r_awvalid || awready;
  assign w_w_done  = !r_wvalid || wready;
  // Beats arriving while no matching wait is open are protocol errors, never accepted.
  assign w_stray   = (rvalid && (r_state != RD_DATA)) ||
                     (bvalid && !(r_state inside {WR, WR_RESP}));

  axi_tb_mst_tmo #(.TIMEOUT(TIMEOUT)) u_tmo (
    .i_aclk   (aclk),
    .i_rst_l  (rst_l),
    .i_clear  (w_fire),
    .i_en     (w_tmo_en),
    .o_expire (w_expire)
  );

  always_comb begin
    w_nxt_state       = r_state;
    w_nxt_arvalid     = r_arvalid;
    w_nxt_rready      = r_rready;
    w_nxt_awvalid     = r_awvalid;
    w_nxt_wvalid      = r_wvalid;
    w_nxt_bready      = r_bready;
    w_nxt_bgot        = r_bgot;
    w_nxt_rsp_valid   = r_rsp_valid;
    w_nxt_rsp_resp    = r_rsp_resp;
    w_nxt_rsp_rdata   = r_rsp_rdata;
    w_nxt_err_proto   = r_err_proto || w_stray;
    w_nxt_err_timeout = r_err_timeout;

    case (r_state)
      IDLE: begin
        if (w_fire) begin
          w_nxt_rsp_resp  = RESP_OKAY;
          w_nxt_rsp_rdata = '0;
          w_nxt_bgot      = 1'b0;
          if (is_misaligned(cmd_size, cmd_addr[2:0])) begin
            w_nxt_state     = RSP;
            w_nxt_rsp_valid = 1'b1;
            w_nxt_rsp_resp  = RESP_SLVERR;
          end else if (cmd_write) begin
            w_nxt_state   = WR;
            w_nxt_awvalid = 1'b1;
            w_nxt_wvalid  = 1'b1;
          end else begin
            w_nxt_state   = RD_ADDR;
            w_nxt_arvalid = 1'b1;
          end
        end
      end
      RD_ADDR: begin
        if (arready) begin
          w_nxt_arvalid = 1'b0;
          w_nxt_rready  = 1'b1;
          w_nxt_state   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (rvalid) begin
          w_nxt_rready    = 1'b0;
          w_nxt_rsp_valid = 1'b1;
          w_nxt_rsp_resp  = rresp;
          w_nxt_rsp_rdata = rdata;
          w_nxt_state     = RSP;
          if ((rid != r_tag) || !rlast) w_nxt_err_proto = 1'b1;
        end
      end
      WR: begin
        if (w_aw_hs) w_nxt_awvalid = 1'b0;
        if (w_w_hs)  w_nxt_wvalid  = 1'b0;
        if (w_b_hs) begin
          w_nxt_bgot     = 1'b1;
          w_nxt_rsp_resp = bresp;
          if (bid != r_tag) w_nxt_err_proto = 1'b1;
        end
        // B may legally complete while AW is still stalled; finish only once AW is done too.
        if (w_aw_done && (r_bgot || w_b_hs)) begin
          w_nxt_bready    = 1'b0;
          w_nxt_rsp_valid = 1'b1;
          w_nxt_state     = RSP;
        end else if (w_aw_done && w_w_done) begin
          w_nxt_bready = 1'b1;
          w_nxt_state  = WR_RESP;
        end else begin
          w_nxt_bready = w_w_done && !r_bgot && !w_b_hs;
        end
      end
      WR_RESP: begin
        if (w_b_hs) begin
          w_nxt_bready    = 1'b0;
          w_nxt_rsp_valid = 1'b1;
          w_nxt_rsp_resp  = bresp;
          w_nxt_state     = RSP;
          if (bid != r_tag) w_nxt_err_proto = 1'b1;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          w_nxt_rsp_valid = 1'b0;
          w_nxt_state     = IDLE;
        end
      end
      default: w_nxt_state = IDLE;
    endcase

    if (w_expire) begin
      w_nxt_arvalid     = 1'b0;
      w_nxt_rready      = 1'b0;
      w_nxt_awvalid     = 1'b0;
      w_nxt_wvalid      = 1'b0;
      w_nxt_bready      = 1'b0;
      w_nxt_rsp_valid   = 1'b1;
      w_nxt_rsp_resp    = RESP_DECERR;
      w_nxt_rsp_rdata   = '0;
      w_nxt_err_timeout = 1'b1;
      w_nxt_state       = RSP;
    end
  end

  always_ff @(posedge aclk or negedge rst_l) begin
    if (!rst_l) begin
      r_state       <= IDLE;
      r_write       <= 1'b0;
      r_size        <= '0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
      r_tag         <= '0;
      r_arvalid     <= 1'b0;
      r_rready      <= 1'b0;
      r_awvalid     <= 1'b0;
      r_wvalid      <= 1'b0;
      r_bready      <= 1'b0;
      r_bgot        <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_resp    <= '0;
      r_rsp_rdata   <= '0;
      r_err_proto   <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_state       <= w_nxt_state;
      r_arvalid     <= w_nxt_arvalid;
      r_rready      <= w_nxt_rready;
      r_awvalid     <= w_nxt_awvalid;
      r_wvalid      <= w_nxt_wvalid;
      r_bready      <= w_nxt_bready;
      r_bgot        <= w_nxt_bgot;
      r_rsp_valid   <= w_nxt_rsp_valid;
      r_rsp_resp    <= w_nxt_rsp_resp;
      r_rsp_rdata   <= w_nxt_rsp_rdata;
      r_err_proto   <= w_nxt_err_proto;
      r_err_timeout <= w_nxt_err_timeout;
      if (w_fire) begin
        r_write <= cmd_write;
        r_size  <= cmd_size;
        r_addr  <= cmd_addr;
        r_wdata <= cmd_wdata;
        r_wstrb <= size_to_strb(cmd_size, cmd_addr[2:0]);
        r_tag   <= cmd_tag;
      end
    end
  end

  assign cmd_ready   = (r_state == IDLE);
  assign busy        = (r_state != IDLE);
  assign rsp_valid   = r_rsp_valid;
  assign rsp_write   = r_write;
  assign rsp_resp    = r_rsp_resp;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_tag     = r_tag;
  assign arvalid     = r_arvalid;
  assign araddr      = r_addr;
  assign arid        = r_tag;
  assign arlen       = 8'd0;
  assign arburst     = BURST_INCR;
  assign arsize      = r_size;
  assign rready      = r_rready;
  assign awvalid     = r_awvalid;
  assign awaddr      = r_addr;
  assign awid        = r_tag;
  assign awlen       = 8'd0;
  assign awburst     = BURST_INCR;
  assign awsize      = r_size;
  assign wvalid      = r_wvalid;
  assign wdata       = r_wdata;
  assign wstrb       = r_wstrb;
  assign wlast       = 1'b1;
  assign bready      = r_bready;
  assign err_proto   = r_err_proto;
  assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_axi_tb_mst.sv
// Bench for axi_tb_mst: a behavioural AXI subordinate memory plus a byte-level reference model.
// Each scenario task drives commands and checks responses, bus timing and error flags.
module tb_axi_tb_mst;

  localparam int TAGW = 1;
  localparam int TMO  = 16;

  logic            aclk = 1'b0;
  logic            rst_l;
  logic            cmd_valid, cmd_ready, cmd_write;
  logic [2:0]      cmd_size;
  logic [31:0]     cmd_addr;
  logic [63:0]     cmd_wdata;
  logic [TAGW-1:0] cmd_tag;
  logic            rsp_valid, rsp_ready, rsp_write;
  logic [1:0]      rsp_resp;
  logic [63:0]     rsp_rdata;
  logic [TAGW-1:0] rsp_tag;
  logic            arvalid, arready;
  logic [31:0]     araddr;
  logic [TAGW-1:0] arid;
  logic [7:0]      arlen;
  logic [1:0]      arburst;
  logic [2:0]      arsize;
  logic            rvalid, rready, rlast;
  logic [63:0]     rdata;
  logic [1:0]      rresp;
  logic [TAGW-1:0] rid;
  logic            awvalid, awready;
  logic [31:0]     awaddr;
  logic [TAGW-1:0] awid;
  logic [7:0]      awlen;
  logic [1:0]      awburst;
  logic [2:0]      awsize;
  logic            wvalid, wready, wlast;
  logic [63:0]     wdata;
  logic [7:0]      wstrb;
  logic            bvalid, bready;
  logic [1:0]      bresp;
  logic [TAGW-1:0] bid;
  logic            busy, err_proto, err_timeout;

  always #5 aclk = ~aclk;

  axi_tb_mst #(.TAGW(TAGW), .TIMEOUT(TMO)) dut (
    .aclk(aclk), .rst_l(rst_l),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_tag(cmd_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_resp(rsp_resp), .rsp_rdata(rsp_rdata), .rsp_tag(rsp_tag),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arburst(arburst), .arsize(arsize),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rid(rid), .rlast(rlast),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
    .awlen(awlen), .awburst(awburst), .awsize(awsize),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .busy(busy), .err_proto(err_proto), .err_timeout(err_timeout)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Subordinate knobs, written only by the test sequence.
  bit              ar_block = 1'b0;
  bit              r_hold   = 1'b0;
  bit              b_early  = 1'b0;
  logic [TAGW-1:0] rid_flip = '0;
  int              aw_hold  = 0;

  // Subordinate state, written only by the subordinate process.
  logic [63:0]     smem [logic [31:0]];
  bit              got_aw, got_w;
  int              aw_cnt;
  logic [31:0]     s_awaddr;
  logic [TAGW-1:0] s_awid;
  logic [63:0]     s_wdata;
  logic [7:0]      s_wstrb, last_wstrb;
  bit              bad_burst;

  initial begin
    bit hs_ar, hs_r, hs_aw, hs_w, hs_b, aw_pend;
    logic [31:0] c_araddr, c_awaddr, key;
    logic [TAGW-1:0] c_arid, c_awid;
    logic [63:0] c_wdata, tmp;
    logic [7:0] c_wstrb;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; rid = '0; rlast = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0; bid = '0;
    got_aw = 0; got_w = 0; aw_cnt = 0; s_awaddr = '0; s_awid = '0; s_wdata = '0;
    s_wstrb = '0; last_wstrb = '0; bad_burst = 0;
    forever begin
      @(negedge aclk);
      hs_ar = arvalid && arready;  hs_r = rvalid && rready;
      hs_aw = awvalid && awready;  hs_w = wvalid && wready;  hs_b = bvalid && bready;
      aw_pend = awvalid && !awready;
      c_araddr = araddr; c_arid = arid; c_awaddr = awaddr; c_awid = awid;
      c_wdata = wdata; c_wstrb = wstrb;
      if ((hs_ar && (arlen != 8'd0 || arburst != 2'b01)) ||
          (hs_aw && (awlen != 8'd0 || awburst != 2'b01)) || (hs_w && !wlast))
        bad_burst = 1;
      @(posedge aclk);
      #1;
      if (!rst_l) begin
        rvalid = 1'b0; bvalid = 1'b0; got_aw = 0; got_w = 0; aw_cnt = 0;
        continue;
      end
      if (hs_r) rvalid = 1'b0;
      if (hs_b) bvalid = 1'b0;
      if (hs_ar && !r_hold) begin
        key   = {c_araddr[31:3], 3'b000};
        rdata = smem.exists(key) ? smem[key] : 64'd0;
        rid   = c_arid ^ rid_flip;
        rresp = 2'b00;
        rlast = 1'b1;
        rvalid = 1'b1;
      end
      if (hs_aw) aw_cnt = 0;
      else if (aw_pend) aw_cnt++;
      awready = (aw_cnt >= aw_hold);
      arready = !ar_block;
      wready  = 1'b1;
      if (hs_aw) begin got_aw = 1; s_awaddr = c_awaddr; s_awid = c_awid; end
      if (hs_w) begin
        got_w = 1; s_wdata = c_wdata; s_wstrb = c_wstrb; last_wstrb = c_wstrb;
        if (b_early) begin bvalid = 1'b1; bid = c_awid; bresp = 2'b00; end
      end
      if (got_aw && got_w) begin
        key = {s_awaddr[31:3], 3'b000};
        tmp = smem.exists(key) ? smem[key] : 64'd0;
        for (int b = 0; b < 8; b++) if (s_wstrb[b]) tmp[b*8 +: 8] = s_wdata[b*8 +: 8];
        smem[key] = tmp;
        got_aw = 0; got_w = 0;
        if (!b_early) begin bvalid = 1'b1; bid = s_awid; bresp = 2'b00; end
      end
    end
  end

  // Reference model: flat byte memory and the AXI alignment rule.
  logic [7:0] ref_bytes [logic [31:0]];

  function automatic bit model_misaligned(input logic [2:0] sz, input logic [31:0] ad);
    if (sz > 3'd3) return 1'b1;
    return (ad % (32'd1 << sz)) != 0;
  endfunction

  task automatic model_write(input logic [2:0] sz, input logic [31:0] ad, input logic [63:0] wd);
    for (int i = 0; i < (1 << sz); i++) ref_bytes[ad + i] = wd[((ad % 8) + i) * 8 +: 8];
  endtask

  function automatic logic [63:0] model_read(input logic [31:0] ad);
    logic [63:0] v;
    logic [31:0] base;
    base = ad - (ad % 8);
    for (int l = 0; l < 8; l++)
      v[l*8 +: 8] = ref_bytes.exists(base + l) ? ref_bytes[base + l] : 8'h00;
    return v;
  endfunction

  // Results of the last command, filled in by do_cmd.
  logic [1:0]      g_resp;
  logic [63:0]     g_rdata;
  logic [TAGW-1:0] g_rtag;
  logic            g_rwrite;
  bit              g_ok;
  int              g_lat, g_nar, g_naw, g_nw;

  task automatic do_cmd(input logic w, input logic [2:0] sz, input logic [31:0] ad,
                        input logic [63:0] wd, input logic [TAGW-1:0] tg);
    g_ok = 0; g_lat = -1; g_nar = 0; g_naw = 0; g_nw = 0;
    @(posedge aclk);
    #1;
    cmd_valid = 1'b1; cmd_write = w; cmd_size = sz; cmd_addr = ad; cmd_wdata = wd; cmd_tag = tg;
    @(posedge aclk);
    #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge aclk);
      if (rsp_valid) begin
        g_resp = rsp_resp; g_rdata = rsp_rdata; g_rtag = rsp_tag; g_rwrite = rsp_write;
        g_ok = 1; g_lat = i;
        break;
      end
      if (arvalid) g_nar++;
      if (awvalid) g_naw++;
      if (wvalid)  g_nw++;
    end
    if (g_ok) begin
      rsp_ready = 1'b1;
      @(posedge aclk);
      #1;
      rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    obs = {cmd_ready, busy, arvalid, awvalid, wvalid, rready, bready, rsp_valid, err_proto, err_timeout};
    n_cmp++;
    if (obs !== 10'b10_0000_0000) begin
      n_fail++;
      $display("[TB] FAIL reset_state: got %b want %b", obs, 10'b10_0000_0000);
    end
  endtask

  task automatic test_write_read();
    do_cmd(1'b1, 3'd3, 32'h1000, 64'h1122334455667788, 1'b1);
    model_write(3'd3, 32'h1000, 64'h1122334455667788);
    n_cmp++;
    if (!g_ok || g_resp !== 2'b00 || g_rwrite !== 1'b1 || g_rtag !== 1'b1 || g_rdata !== 64'd0) begin
      n_fail++;
      $display("[TB] FAIL wr64_rsp: ok=%0d resp=%b write=%b tag=%h rdata=%h want ok=1 resp=00 write=1 tag=1 rdata=0",
               g_ok, g_resp, g_rwrite, g_rtag, g_rdata);
    end
    do_cmd(1'b0, 3'd3, 32'h1000, 64'd0, 1'b0);
    n_cmp++;
    if (!g_ok || g_resp !== 2'b00 || g_rtag !== 1'b0 || g_rdata !== 64'h1122334455667788) begin
      n_fail++;
      $display("[TB] FAIL rd64: ok=%0d resp=%b tag=%h rdata=%h want resp=00 tag=0 rdata=1122334455667788",
               g_ok, g_resp, g_rtag, g_rdata);
    end
  endtask

  task automatic test_byte_write();
    do_cmd(1'b1, 3'd0, 32'h1003, 64'hAB << 24, 1'b0);
    model_write(3'd0, 32'h1003, 64'hAB << 24);
    n_cmp++;
    if (!g_ok || last_wstrb !== 8'h08) begin
      n_fail++;
      $display("[TB] FAIL byte_wstrb: ok=%0d wstrb=%h want 08", g_ok, last_wstrb);
    end
    do_cmd(1'b0, 3'd3, 32'h1000, 64'd0, 1'b0);
    n_cmp++;
    if (!g_ok || g_rdata !== 64'h11223344AB667788 || g_rdata !== model_read(32'h1000)) begin
      n_fail++;
      $display("[TB] FAIL byte_readback: got %h want %h", g_rdata, 64'h11223344AB667788);
    end
  endtask

  task automatic test_misaligned();
    do_cmd(1'b0, 3'd2, 32'h1002, 64'd0, 1'b1);
    n_cmp++;
    if (!g_ok || g_resp !== 2'b10 || g_rdata !== 64'd0 || (g_nar + g_naw) != 0 || g_lat > 2) begin
      n_fail++;
      $display("[TB] FAIL misaligned: ok=%0d resp=%b rdata=%h bus_valids=%0d lat=%0d want resp=10 rdata=0 valids=0 lat<=2",
               g_ok, g_resp, g_rdata, g_nar + g_naw, g_lat);
    end
  endtask

  task automatic test_early_b();
    int extra;
    aw_hold = 5;
    b_early = 1'b1;
    do_cmd(1'b1, 3'd2, 32'h1010, 64'hCAFEF00D_00000000, 1'b1);
    model_write(3'd2, 32'h1010, 64'hCAFEF00D_00000000);
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge aclk);
      if (rsp_valid) extra++;
    end
    aw_hold = 0;
    b_early = 1'b0;
    n_cmp++;
    if (g_nw != 1 || g_naw != 6) begin
      n_fail++;
      $display("[TB] FAIL early_b_timing: wvalid_cycles=%0d awvalid_cycles=%0d want 1 and 6", g_nw, g_naw);
    end
    n_cmp++;
    if (!g_ok || g_resp !== 2'b00 || extra != 0) begin
      n_fail++;
      $display("[TB] FAIL early_b_rsp: ok=%0d resp=%b extra_rsp=%0d want ok=1 resp=00 extra=0", g_ok, g_resp, extra);
    end
  endtask

  task automatic test_random();
    logic [2:0] sz;
    logic [31:0] ad;
    logic [63:0] wd, exp_rd;
    logic [1:0] exp_resp;
    logic w;
    logic [TAGW-1:0] tg;
    int bad = 0;
    for (int n = 0; n < 40; n++) begin
      sz = 3'($urandom_range(0, 4));
      if (sz == 3'd4) sz = 3'($urandom_range(4, 7));
      ad = 32'h2000 + 32'($urandom_range(0, 31));
      if ($urandom_range(0, 2) != 0 && sz <= 3'd3) ad = ad & ~((32'd1 << sz) - 32'd1);
      wd = {$urandom, $urandom};
      w  = 1'($urandom_range(0, 1));
      tg = TAGW'($urandom_range(0, 1));
      aw_hold = $urandom_range(0, 3);
      b_early = 1'($urandom_range(0, 1));
      do_cmd(w, sz, ad, wd, tg);
      if (model_misaligned(sz, ad)) begin
        exp_resp = 2'b10; exp_rd = 64'd0;
      end else if (w) begin
        exp_resp = 2'b00; exp_rd = 64'd0;
        model_write(sz, ad, wd);
      end else begin
        exp_resp = 2'b00; exp_rd = model_read(ad);
      end
      n_cmp++;
      if (!g_ok || g_resp !== exp_resp || g_rdata !== exp_rd || g_rtag !== tg || g_rwrite !== w) begin
        n_fail++;
        bad++;
        if (bad < 5)
          $display("[TB] FAIL random_%0d: w=%b sz=%0d ad=%h got ok=%0d resp=%b rdata=%h tag=%h write=%b want resp=%b rdata=%h tag=%h",
                   n, w, sz, ad, g_ok, g_resp, g_rdata, g_rtag, g_rwrite, exp_resp, exp_rd, tg);
      end
    end
    aw_hold = 0;
    b_early = 1'b0;
    n_cmp++;
    if (err_proto !== 1'b0 || err_timeout !== 1'b0 || bad_burst) begin
      n_fail++;
      $display("[TB] FAIL random_flags: err_proto=%b err_timeout=%b bad_burst=%0d want 0 0 0",
               err_proto, err_timeout, bad_burst);
    end
  endtask

  task automatic test_timeout();
    ar_block = 1'b1;
    do_cmd(1'b0, 3'd3, 32'h1000, 64'd0, 1'b0);
    ar_block = 1'b0;
    n_cmp++;
    if (!g_ok || g_nar != TMO || g_resp !== 2'b11 || err_timeout !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL timeout: ok=%0d arvalid_cycles=%0d resp=%b err_timeout=%b want 16 11 1",
               g_ok, g_nar, g_resp, err_timeout);
    end
    do_cmd(1'b0, 3'd3, 32'h1000, 64'd0, 1'b1);
    n_cmp++;
    if (!g_ok || g_resp !== 2'b00 || g_rdata !== model_read(32'h1000) || err_timeout !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL timeout_sticky: ok=%0d resp=%b rdata=%h err_timeout=%b want resp=00 rdata=%h err_timeout=1",
               g_ok, g_resp, g_rdata, err_timeout, model_read(32'h1000));
    end
  endtask

  task automatic test_rid_reset();
    bit seen;
    logic [9:0] obs;
    rid_flip = 1'b1;
    do_cmd(1'b0, 3'd3, 32'h1000, 64'd0, 1'b0);
    rid_flip = 1'b0;
    n_cmp++;
    if (!g_ok || g_rtag !== 1'b0 || err_proto !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL rid_mismatch: ok=%0d tag=%h err_proto=%b want ok=1 tag=0 err_proto=1", g_ok, g_rtag, err_proto);
    end
    r_hold = 1'b1;
    @(posedge aclk);
    #1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_size = 3'd3; cmd_addr = 32'h1008; cmd_tag = 1'b1;
    @(posedge aclk);
    #1;
    cmd_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge aclk);
      if (rready) seen = 1;
    end
    n_cmp++;
    if (!seen) begin
      n_fail++;
      $display("[TB] FAIL reach_rd_data: rready never seen, want 1");
    end
    #2;
    rst_l = 1'b0;
    #1;
    obs = {cmd_ready, busy, arvalid, awvalid, wvalid, rready, bready, rsp_valid, err_proto, err_timeout};
    n_cmp++;
    if (obs !== 10'b10_0000_0000) begin
      n_fail++;
      $display("[TB] FAIL mid_reset: got %b want %b", obs, 10'b10_0000_0000);
    end
    @(negedge aclk);
    rst_l = 1'b1;
    r_hold = 1'b0;
    repeat (3) @(negedge aclk);
    n_cmp++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL post_reset_idle: rsp_valid=%b busy=%b cmd_ready=%b want 0 0 1", rsp_valid, busy, cmd_ready);
    end
  endtask

  initial begin
    rst_l = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_size = '0; cmd_addr = '0; cmd_wdata = '0; cmd_tag = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    rst_l = 1'b1;
    repeat (2) @(negedge aclk);
    test_reset();
    test_write_read();
    test_byte_write();
    test_misaligned();
    test_early_b();
    test_random();
    test_timeout();
    test_rid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
